// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter
//   Four-requester round-robin arbiter with a registered one-hot grant.
//   Every rising edge the requests are searched starting just after the most
//   recent winner, so the last winner always has the lowest priority.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   req    in   4  request vector, bit i = requester i wants the resource
//   grant  out  4  registered one-hot grant, all zero = idle
module round_robin_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   idx;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               found;

  // Search order is ptr+1, ptr+2, ..., ptr (the index wraps naturally in
  // PTR_W bits). The first set request wins; with no requests the pointer
  // keeps its value so fairness resumes where it left off.
  always_comb begin
    grant_nxt = '0;
    ptr_nxt   = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_nxt[idx] = 1'b1;
        ptr_nxt        = idx;
      end
    end
  end

  // Pointer resets to the last index so the first search starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      ptr   <= PTR_W'(NUM_REQ - 1);
    end else begin
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_last;
  logic [3:0] m_grant;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [8];

  round_robin_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: grant=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_grant = 4'b0000;
  endtask

  // Priority list: the requester after the last winner first, the last
  // winner itself at the end. First requester in that list wins.
  task automatic model_step(input logic [3:0] r);
    int order [4];
    m_grant = 4'b0000;
    for (int k = 0; k < 4; k++) order[k] = (m_last + 1 + k) % 4;
    for (int k = 0; k < 4; k++) begin
      if (r[order[k]]) begin
        m_grant[order[k]] = 1'b1;
        m_last = order[k];
        break;
      end
    end
  endtask

  task automatic drive_cycle(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
    model_step(r);
  endtask

  initial begin
    logic [3:0] rot [4];
    logic [3:0] r;

    tbl[0] = '{4'b0110, 4'b0010};
    tbl[1] = '{4'b1001, 4'b1000};
    tbl[2] = '{4'b0110, 4'b0010};
    tbl[3] = '{4'b1011, 4'b1000};
    tbl[4] = '{4'b1000, 4'b1000};
    tbl[5] = '{4'b0011, 4'b0001};
    tbl[6] = '{4'b0001, 4'b0001};
    tbl[7] = '{4'b1110, 4'b0010};
    rot[0] = 4'b0100; rot[1] = 4'b1000; rot[2] = 4'b0001; rot[3] = 4'b0010;

    // reset asserted between clock edges with all requests high
    #2;
    req = 4'b1111;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_immediate", grant, 4'b0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", grant, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      #1;
      model_step(4'b0000);
      check("post_reset_idle", grant, 4'b0000);
    end

    // directed single-cycle table
    for (int i = 0; i < 8; i++) begin
      drive_cycle(tbl[i].req);
      check($sformatf("table[%0d]", i), grant, tbl[i].exp);
    end

    // full contention from last winner 1
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'b1111);
      check($sformatf("contention[%0d]", i), grant, rot[i % 4]);
    end

    // sole requester
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b0100);
      check("sole", grant, 4'b0100);
    end

    // idle then resume: pointer must survive idle cycles
    drive_cycle(4'b1000);
    check("idle_pre", grant, 4'b1000);
    drive_cycle(4'b0000);
    check("idle0", grant, 4'b0000);
    drive_cycle(4'b0000);
    check("idle1", grant, 4'b0000);
    drive_cycle(4'b1001);
    check("resume", grant, 4'b0001);

    // async reset pulse mid-rotation
    drive_cycle(4'b1111);
    check("midrot0", grant, 4'b0010);
    drive_cycle(4'b1111);
    check("midrot1", grant, 4'b0100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_async", grant, 4'b0000);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    model_step(4'b1111);
    check("midrst_first", grant, 4'b0001);
    check("midrst_model", grant, m_grant);

    // randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      r = 4'($urandom_range(0, 15));
      if (i % 7 == 0) r = 4'b0000;
      drive_cycle(r);
      check($sformatf("random[%0d] req=%b", i, r), grant, m_grant);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Four-requester round-robin arbiter with a registered, one-hot grant.
- Each cycle it grants at most one requester and rotates priority so the most recent winner becomes lowest priority.
- Used in front of a shared resource (bus, memory port) that multiple masters contend for.

Parameters:
- NUM_REQ, 4, number of requesters. The port widths below are fixed at 4; only the value 4 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; bit i high means requester i wants the resource
- grant  output  4  registered one-hot grant; bit i high means requester i owns the resource this cycle; all zero means idle

Behaviour:
- State:
  - grant register, 4 bits.
  - Last-winner pointer ptr, 2 bits, holding the index of the most recent granted requester.
- Reset (rst=1, asynchronous, takes effect immediately, independent of clk):
  - grant=4'b0000.
  - ptr=3, so after reset the search order starts at requester 0.
  - While rst is high, grant stays 0 and req is ignored.
- Arbitration at each rising clk edge with rst=0:
  - Search req starting at index ptr+1 (mod 4) and wrap through ptr, i.e. order ptr+1, ptr+2, ptr+3, ptr.
  - The first asserted bit, index k, wins: grant <= one-hot(k) and ptr <= k.
  - If req == 0: grant <= 0 and ptr is unchanged.
- Latency:
  - req sampled at edge n is reflected in grant after edge n.
  - grant is a pure register output, with no combinational path from req to grant.
- Grant duration and rotation:
  - A grant lasts one cycle and is re-arbitrated every edge.
  - A requester that keeps requesting alongside others is granted again only after every other active requester has been served (at most 3 intervening grants).
  - A sole requester is re-granted every cycle.
- Invariants:
  - grant is always one-hot or zero.
  - grant[i]=1 only if req[i] was 1 at the sampling edge.
  - No starvation: any requester held high is granted within 4 cycles.
- Request withdrawal: a requester dropping req loses its grant at the next edge. No lock or hold mechanism exists.
- Reset mid-operation: grant clears asynchronously. After release, arbitration restarts from index 0 as if freshly reset.
- X on req is not supported; the bench drives req=0 before releasing reset.

Test Plan:
- Reset: hold rst=1 with req=4'b1111 -> grant=0000 immediately and throughout reset. After release with req=0000 -> grant stays 0000.
- Single-cycle sequence, one req value per cycle (driven on negedge) after reset -> grant after each following posedge:
  - 0110 -> 0010
  - 1001 -> 1000
  - 0110 -> 0010
  - 1011 -> 1000
  - 1000 -> 1000
  - 0011 -> 0001
  - 0001 -> 0001
  - 1110 -> 0010
- Full contention: req=1111 held after the grant of 0010 (ptr=1) -> grants 0100, 1000, 0001, 0010, then repeating.
- Sole requester: req=0100 held for 3 cycles -> grant=0100 every cycle.
- Idle then resume: after grant=1000, apply req=0000 for 2 cycles (grant=0000), then req=1001 -> grant=0001, because ptr stayed 3.
- Async reset mid-stream: during req=1111 rotation, pulse rst between clock edges -> grant=0000 without waiting for a clock edge. After release, the first grant is 0001.
